// File: rtl/apb4_slave_ram.sv
// APB4 completer backed by a word-addressed register memory with byte strobes,
// programmable wait states and PSLVERR on range, alignment, read-only and security faults.
module apb4_slave_ram #(
  parameter int unsigned ADDR_SIZE   = 32,
  parameter int unsigned DATA_SIZE   = 32,
  parameter int unsigned BASE_ADDR   = 0,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned RO_WORDS    = 0,
  parameter int unsigned SECURE_ONLY = 0
) (
  input  logic                   PCLK,
  input  logic                   PRESETn,
  input  logic [ADDR_SIZE-1:0]   PADDR,
  input  logic [2:0]             PPROT,
  input  logic                   PSEL,
  input  logic                   PENABLE,
  input  logic                   PWRITE,
  input  logic [DATA_SIZE-1:0]   PWDATA,
  input  logic [DATA_SIZE/8-1:0] PSTRB,
  output logic [DATA_SIZE-1:0]   PRDATA,
  output logic                   PREADY,
  output logic                   PSLVERR
);

  localparam int unsigned NBYTES = DATA_SIZE / 8;
  localparam int unsigned LSB    = $clog2(NBYTES);
  localparam int unsigned IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [ADDR_SIZE-1:0] BASE       = ADDR_SIZE'(BASE_ADDR);
  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ADDR_SIZE'((1 << LSB) - 1);
  localparam logic [ADDR_SIZE-1:0] DEPTH_A    = ADDR_SIZE'(MEM_DEPTH);
  localparam logic [ADDR_SIZE-1:0] RO_A       = ADDR_SIZE'(RO_WORDS);
  localparam logic [3:0]           WS         = 4'(WAIT_STATES);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e               state_q, state_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic [ADDR_SIZE-1:0] off, idx;
  logic [IDX_W-1:0]     widx;
  logic                 below, range_err, align_err, ro_err, sec_err, err;
  logic                 pready, wr_en, rd_en;
  logic                 unused_pprot;
  logic [DATA_SIZE-1:0] mem [MEM_DEPTH];

  // Borrow out of the subtraction flags addresses below the window.
  always_comb begin
    {below, off} = {1'b0, PADDR} - {1'b0, BASE};
    idx          = off >> LSB;
    widx         = idx[IDX_W-1:0];
    range_err    = idx >= DEPTH_A;
    align_err    = (off & ALIGN_MASK) != '0;
    ro_err       = PWRITE & (idx < RO_A);
    sec_err      = (SECURE_ONLY != 0) & PPROT[1];
    err          = below | range_err | align_err | ro_err | sec_err;
  end

  assign unused_pprot = PPROT[0] ^ PPROT[2];

  // Gating with PRESETn lets a reset mid-transfer drop PREADY at once.
  assign pready  = PRESETn & PSEL & PENABLE & (wcnt_q == WS);
  assign wr_en   = pready & PWRITE & ~err;
  assign rd_en   = pready & ~PWRITE & ~err;
  assign PREADY  = pready;
  assign PSLVERR = pready & err;
  assign PRDATA  = rd_en ? mem[widx] : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StSetup: begin
        if (PSEL && PENABLE) state_d = StAccess;
        else if (PSEL)       state_d = StSetup;
        else                 state_d = StIdle;
      end
      StAccess: begin
        if (!PSEL)         state_d = StIdle;
        else if (!PENABLE) state_d = StSetup;
        else if (pready)   state_d = StIdle;
        else               state_d = StAccess;
      end
      default: state_d = StIdle;
    endcase
  end

  // A skipped setup phase still counts its first enabled cycle as A0.
  always_comb begin
    wcnt_d = '0;
    if (PSEL && PENABLE && !pready) wcnt_d = wcnt_q + 4'd1;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= StIdle;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) mem[i] <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < int'(NBYTES); b++) begin
        if (PSTRB[b]) mem[widx][b*8 +: 8] <= PWDATA[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_apb4_slave_ram.sv
// Directed bench for apb4_slave_ram: four instances cover default timing, RO/secure
// windows, zero wait states and maximum wait states; a scoreboard holds expected responses.
module tb_apb4_slave_ram;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        pclk = 1'b0;
  logic        presetn;
  logic [31:0] paddr, pwdata;
  logic [2:0]  pprot;
  logic [3:0]  psel;
  logic        penable, pwrite;
  logic [3:0]  pstrb;
  logic [31:0] prdata  [4];
  logic        pready  [4];
  logic        pslverr [4];

  int          checks = 0;
  int          errors = 0;
  int          ws [4] = '{2, 2, 0, 15};
  logic [31:0] model [4][64];
  exp_t        sbq [$];

  always #5 pclk = ~pclk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    apb4_slave_ram #(
      .WAIT_STATES((g == 2) ? 0 : (g == 3) ? 15 : 2),
      .RO_WORDS   ((g == 1) ? 4 : 0),
      .SECURE_ONLY((g == 1) ? 1 : 0)
    ) u_dut (
      .PCLK   (pclk),
      .PRESETn(presetn),
      .PADDR  (paddr),
      .PPROT  (pprot),
      .PSEL   (psel[g]),
      .PENABLE(penable),
      .PWRITE (pwrite),
      .PWDATA (pwdata),
      .PSTRB  (pstrb),
      .PRDATA (prdata[g]),
      .PREADY (pready[g]),
      .PSLVERR(pslverr[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_model();
    for (int d = 0; d < 4; d++)
      for (int i = 0; i < 64; i++) model[d][i] = '0;
  endtask

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input int d, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                      input bit skip, input logic exp_err, input string tag);
    exp_t e;
    exp_t got;
    int   cnt;
    int   i;
    i      = int'(addr >> 2);
    e.err  = exp_err;
    e.data = '0;
    if (!exp_err) begin
      if (wr) begin
        for (int b = 0; b < 4; b++) if (strb[b]) model[d][i][b*8 +: 8] = data[b*8 +: 8];
      end else begin
        e.data = model[d][i];
      end
    end
    sbq.push_back(e);
    paddr  = addr;
    pwrite = wr;
    pwdata = data;
    pstrb  = strb;
    pprot  = prot;
    psel   = 4'b0001 << d;
    if (!skip) begin
      penable = 1'b0;
      @(posedge pclk);
      #1;
    end
    penable = 1'b1;
    cnt = 0;
    @(negedge pclk);
    while (!pready[d] && cnt < 40) begin
      cnt++;
      @(negedge pclk);
    end
    chk({tag, "_wait"}, 32'(cnt), 32'(ws[d]));
    got = sbq.pop_front();
    chk({tag, "_pslverr"}, {31'd0, pslverr[d]}, {31'd0, got.err});
    chk({tag, "_prdata"}, prdata[d], got.data);
    @(posedge pclk);
    #1;
    psel    = '0;
    penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected summary line");
    $fatal(1);
  end

  initial begin
    presetn = 1'b0;
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    pstrb   = '0;
    pprot   = '0;
    zero_model();
    repeat (2) @(posedge pclk);
    #1;
    for (int d = 0; d < 4; d++) begin
      chk("reset_pready", {31'd0, pready[d]}, 32'd0);
      chk("reset_pslverr", {31'd0, pslverr[d]}, 32'd0);
      chk("reset_prdata", prdata[d], 32'd0);
    end
    @(negedge pclk);
    presetn = 1'b1;
    idle(1);

    // Default instance: strobed write, readback, skipped setup phase.
    xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1011, 3'b000, 0, 1'b0, "wr10");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'b0000, 3'b000, 0, 1'b0, "rd10");
    idle(1);
    xfer(0, 1'b1, 32'h04, 32'h12345678, 4'hF, 3'b000, 1, 1'b0, "wr04_nosetup");
    idle(1);
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd04");
    xfer(0, 1'b1, 32'h0C, 32'h55555555, 4'h0, 3'b000, 0, 1'b0, "wr0c_nostrb");
    xfer(0, 1'b0, 32'h0C, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd0c");

    // Range and alignment faults leave memory alone.
    xfer(0, 1'b1, 32'h100, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 1'b1, "wr100_range");
    xfer(0, 1'b0, 32'h100, 32'h0, 4'h0, 3'b000, 0, 1'b1, "rd100_range");
    xfer(0, 1'b1, 32'h02, 32'hFFFFFFFF, 4'hF, 3'b000, 0, 1'b1, "wr02_align");
    xfer(0, 1'b0, 32'h02, 32'h0, 4'h0, 3'b000, 0, 1'b1, "rd02_align");
    xfer(0, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd00_unchanged");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd10_unchanged");

    // Read-only window and secure-only mode.
    xfer(1, 1'b1, 32'h08, 32'hA5A5A5A5, 4'hF, 3'b000, 0, 1'b1, "wr08_ro");
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd08_secure");
    xfer(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b010, 0, 1'b1, "rd08_nonsecure");
    xfer(1, 1'b1, 32'h20, 32'h0BADCAFE, 4'hF, 3'b000, 0, 1'b0, "wr20_secure");
    xfer(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b010, 0, 1'b1, "wr20_nonsecure");
    xfer(1, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001, 0, 1'b0, "rd20");

    // Zero wait states: ten back-to-back writes then readback.
    xfer(2, 1'b0, 32'h00, 32'h0, 4'h0, 3'b000, 0, 1'b0, "ws0_rd00");
    for (int k = 0; k < 10; k++)
      xfer(2, 1'b1, 32'(4 * (k + 3)), 32'h11111111 * (k + 1), 4'hF, 3'b000, 0, 1'b0, "ws0_wr");
    for (int k = 0; k < 10; k++)
      xfer(2, 1'b0, 32'(4 * (k + 3)), 32'h0, 4'h0, 3'b000, 0, 1'b0, "ws0_rd");

    // Maximum wait states.
    xfer(3, 1'b1, 32'h3C, 32'hCAFEF00D, 4'hF, 3'b000, 0, 1'b0, "ws15_wr");
    xfer(3, 1'b0, 32'h3C, 32'h0, 4'h0, 3'b000, 0, 1'b0, "ws15_rd");
    idle(1);

    // Reset pulsed at wait cycle 1 of an in-flight write.
    paddr   = 32'h20;
    pwrite  = 1'b1;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'hF;
    pprot   = 3'b000;
    psel    = 4'b0001;
    penable = 1'b0;
    idle(1);
    penable = 1'b1;
    idle(1);
    presetn = 1'b0;
    #1;
    chk("rst_inflight_pready", {31'd0, pready[0]}, 32'd0);
    chk("rst_inflight_pslverr", {31'd0, pslverr[0]}, 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    zero_model();
    idle(1);
    xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd20_after_rst");
    xfer(0, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd10_after_rst");

    // Reset while a zero-wait transfer is showing PREADY.
    paddr   = 32'h08;
    pwrite  = 1'b1;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'hF;
    psel    = 4'b0100;
    penable = 1'b1;
    #1;
    chk("ws0_pready_before_rst", {31'd0, pready[2]}, 32'd1);
    presetn = 1'b0;
    #1;
    chk("ws0_pready_in_rst", {31'd0, pready[2]}, 32'd0);
    psel    = '0;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    idle(1);
    xfer(2, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000, 0, 1'b0, "ws0_rd08_after_rst");

    // PSEL dropped mid-ACCESS.
    paddr   = 32'h24;
    pwrite  = 1'b1;
    pwdata  = 32'hFFFFFFFF;
    pstrb   = 4'hF;
    psel    = 4'b0001;
    penable = 1'b0;
    idle(1);
    penable = 1'b1;
    idle(1);
    psel    = '0;
    penable = 1'b0;
    idle(3);
    xfer(0, 1'b0, 32'h24, 32'h0, 4'h0, 3'b000, 0, 1'b0, "rd24_after_drop");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
